// File: rtl/rsa_decrypt_engine.sv
`default_nettype none
// ============================================================================
// Module      : rsa_decrypt_engine
// Description : Recovers RSA plaintext m = c^D mod N from a 16-bit ciphertext
//               using left-to-right square-and-multiply over the private
//               exponent. The engine sequences itself with a small FSM and
//               offers a start/busy/valid handshake, plus an err pulse when a
//               ciphertext outside the residue range [0, N) is presented.
//               The default key pair matches the encrypt side:
//               N = 3233, e = 17, so D = 2753.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N       modulus, must be < 2^16                          (default 3233)
//   D       private exponent                                 (default 2753)
//   D_BITS  number of exponent bits scanned, MSB first       (default 12)
// Ports
//   clk     in   1   rising-edge clock
//   rst_n   in   1   asynchronous active-low reset
//   start   in   1   decryption request, sampled only while idle
//   cipher  in   16  ciphertext, captured on the accepted start edge
//   busy    out  1   high while a decryption is in progress
//   valid   out  1   one-cycle pulse, plain carries a new result
//   err     out  1   one-cycle pulse, a ciphertext >= N was rejected
//   plain   out  16  last result c^D mod N, held until next valid or reset
// ============================================================================
module rsa_decrypt_engine #(
    parameter int N      = 3233,
    parameter int D      = 2753,
    parameter int D_BITS = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] cipher,
    output logic        busy,
    output logic        valid,
    output logic        err,
    output logic [15:0] plain
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // Exponent bit index width; a single-bit exponent still needs a 1-bit
    // index register.
    localparam int IDX_W = (D_BITS > 1) ? $clog2(D_BITS) : 1;

    localparam logic [15:0]       C_N16     = 16'(N);
    localparam logic [31:0]       C_N32     = 32'(N);
    localparam logic [D_BITS-1:0] C_D       = D_BITS'(D);
    localparam logic [IDX_W-1:0]  C_IDX_TOP = IDX_W'(D_BITS - 1);
    localparam logic [15:0]       C_ONE     = 16'd1;

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SQ      = 3'd1;
    localparam logic [2:0] S_SQ_RED  = 3'd2;
    localparam logic [2:0] S_MUL     = 3'd3;
    localparam logic [2:0] S_MUL_RED = 3'd4;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [2:0]       r_state;
    logic [15:0]      r_c;        // captured ciphertext, immune to later changes
    logic [15:0]      r_acc;      // running result, always reduced below N
    logic [31:0]      r_prod;     // full-width product awaiting reduction
    logic [IDX_W-1:0] r_bit_idx;  // exponent bit currently being processed
    logic             r_busy;
    logic             r_valid;
    logic             r_err;
    logic [15:0]      r_plain;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [15:0] w_rem;       // exact residue of the pending product
    logic        w_dbit;      // exponent bit selected by r_bit_idx
    logic        w_last_bit;  // the bit being processed is bit 0
    logic        w_cipher_ok; // ciphertext is a valid residue

    // Both operands of every product are below N < 2^16, so the 32-bit
    // product is exact and its residue always fits in 16 bits.
    assign w_rem       = 16'(r_prod % C_N32);
    assign w_dbit      = C_D[r_bit_idx];
    assign w_last_bit  = (r_bit_idx == '0);
    assign w_cipher_ok = (cipher < C_N16);

    // ------------------------------------------------------------------------
    // Sequencer and datapath
    // ------------------------------------------------------------------------
    // Each exponent bit costs a square (SQ + SQ_RED) and, when the bit is
    // set, an extra multiply by the ciphertext (MUL + MUL_RED). The result
    // is taken straight from the final reduction so that valid appears in
    // the cycle right after the last work cycle, with the FSM already idle
    // and able to accept a new request in that same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_c       <= '0;
            r_acc     <= '0;
            r_prod    <= '0;
            r_bit_idx <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_plain   <= '0;
        end else begin
            // Status pulses last exactly one cycle unless re-armed below.
            r_valid <= 1'b0;
            r_err   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_cipher_ok) begin
                            r_c       <= cipher;
                            r_acc     <= C_ONE;
                            r_bit_idx <= C_IDX_TOP;
                            r_busy    <= 1'b1;
                            r_state   <= S_SQ;
                        end else begin
                            // Out-of-range ciphertext: flag it and stay idle.
                            r_err <= 1'b1;
                        end
                    end
                end

                S_SQ: begin
                    r_prod  <= 32'(r_acc) * 32'(r_acc);
                    r_state <= S_SQ_RED;
                end

                S_SQ_RED: begin
                    r_acc <= w_rem;
                    if (w_dbit) begin
                        r_state <= S_MUL;
                    end else if (w_last_bit) begin
                        r_plain <= w_rem;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_bit_idx <= r_bit_idx - 1'b1;
                        r_state   <= S_SQ;
                    end
                end

                S_MUL: begin
                    r_prod  <= 32'(r_acc) * 32'(r_c);
                    r_state <= S_MUL_RED;
                end

                S_MUL_RED: begin
                    r_acc <= w_rem;
                    if (w_last_bit) begin
                        r_plain <= w_rem;
                        r_valid <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_bit_idx <= r_bit_idx - 1'b1;
                        r_state   <= S_SQ;
                    end
                end

                default: begin
                    // Unreachable encodings recover to idle.
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign busy  = r_busy;
    assign valid = r_valid;
    assign err   = r_err;
    assign plain = r_plain;

endmodule
`default_nettype wire

// File: tb/tb_rsa_decrypt_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_rsa_decrypt_engine
// Description : Self-checking bench for rsa_decrypt_engine. Expected results
//               are queued when a request is driven and compared when the
//               engine raises valid; latency and status pulses are checked
//               alongside.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rsa_decrypt_engine;

    localparam int TB_N   = 3233;
    localparam int TB_D   = 2753;
    localparam int TB_LAT = 34;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [15:0] cipher = 16'd0;
    logic        busy;
    logic        valid;
    logic        err;
    logic [15:0] plain;

    rsa_decrypt_engine #(
        .N      (TB_N),
        .D      (TB_D),
        .D_BITS (12)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .cipher (cipher),
        .busy   (busy),
        .valid  (valid),
        .err    (err),
        .plain  (plain)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] val;
        int          acc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks         = 0;
    int          errors         = 0;
    logic [15:0] last_plain     = 16'd0;
    int          last_valid_cyc = 0;
    int          valid_gap      = 0;

    // Reference: right-to-left modular exponentiation on wide integers.
    function automatic logic [15:0] ref_modpow(input logic [15:0] c);
        longint unsigned r, b, e;
        r = 1;
        b = longint'(c) % TB_N;
        e = TB_D;
        while (e != 0) begin
            if (e[0]) r = (r * b) % TB_N;
            b = (b * b) % TB_N;
            e = e >> 1;
        end
        return 16'(r);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks = checks + 1;
        if (obs !== expv) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            last_plain = 16'd0;
        end else begin
            if (valid || err)
                check("valid_err_excl", 32'(valid & err), 32'd0);
            if (valid) begin
                valid_gap      = cyc - last_valid_cyc;
                last_valid_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(plain), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("plain", 32'(plain), 32'(mon_e.val));
                    check("latency", 32'(cyc - mon_e.acc), 32'(TB_LAT));
                    check("busy_on_valid", 32'(busy), 32'd0);
                    last_plain = mon_e.val;
                end
            end
        end
    end

    task automatic drive(input logic [15:0] c, input logic [15:0] expv, input bit accept);
        exp_t e;
        @(negedge clk);
        start  = 1'b1;
        cipher = c;
        if (accept) begin
            e.val = expv;
            e.acc = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy) return;
        end
        check("timeout", 32'd1, 32'd0);
    endtask

    logic [15:0] vec_in [3] = '{16'd0, 16'd1, 16'd3232};
    logic [15:0] bad_in [2] = '{16'd3233, 16'hFFFF};

    initial begin
        bit found;
        logic [15:0] rc;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_err",   32'(err),   32'd0);
        check("rst_plain", 32'(plain), 32'd0);
        rst_n = 1'b1;

        // Inverse of encrypting 65
        drive(16'd2790, 16'd65, 1'b1);
        wait_done(200);

        // Edge residues: 0, 1 and N-1 (odd exponent keeps -1)
        foreach (vec_in[i]) begin
            drive(vec_in[i], vec_in[i], 1'b1);
            wait_done(200);
        end

        // Out-of-range ciphertexts are rejected with a single err pulse
        foreach (bad_in[i]) begin
            @(negedge clk);
            start  = 1'b1;
            cipher = bad_in[i];
            @(negedge clk);
            start = 1'b0;
            check("err_pulse",     32'(err),   32'd1);
            check("err_busy",      32'(busy),  32'd0);
            @(negedge clk);
            check("err_one_cycle", 32'(err),   32'd0);
            check("err_busy_after",32'(busy),  32'd0);
            check("err_plain_held",32'(plain), 32'(last_plain));
            repeat (5) @(negedge clk);
        end

        // Starts while busy are ignored; cipher changes do not disturb result
        drive(16'd2790, 16'd65, 1'b1);
        repeat (4) @(negedge clk);
        drive(16'd100, 16'd0, 1'b0);
        cipher = 16'd200;
        repeat (13) @(negedge clk);
        drive(16'd300, 16'd0, 1'b0);
        cipher = 16'd555;
        wait_done(200);
        repeat (40) @(negedge clk);
        check("ignored_start_busy", 32'(busy), 32'd0);

        // Reset in the middle of a run
        drive(16'd2790, 16'd65, 1'b1);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",  32'(busy),  32'd0);
        check("midrst_valid", 32'(valid), 32'd0);
        check("midrst_plain", 32'(plain), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_no_valid_busy", 32'(busy), 32'd0);
        drive(16'd2790, 16'd65, 1'b1);
        wait_done(200);

        // Back-to-back: next start lands in the valid cycle
        drive(16'd2790, 16'd65, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (valid) begin
                found = 1'b1;
                break;
            end
        end
        check("b2b_first_valid", 32'(found), 32'd1);
        begin
            exp_t e;
            start  = 1'b1;
            cipher = 16'd1;
            e.val  = 16'd1;
            e.acc  = cyc + 1;
            exp_q.push_back(e);
            @(negedge clk);
            start = 1'b0;
        end
        wait_done(200);
        check("b2b_gap", 32'(valid_gap), 32'd35);

        // Random sweep against the reference model
        for (int i = 0; i < 12; i++) begin
            rc = 16'($urandom_range(0, TB_N - 1));
            drive(rc, ref_modpow(rc), 1'b1);
            wait_done(200);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
